// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx core: fetch FSM states, reset PC, NOP encoding.
// No ports; imported by the fetch unit and anything that needs the same constants.
// ST_FAULT is sticky and is left only through a redirect from execute.
package ysyx_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } ifu_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_ifu_npc.sv
// Next-PC select for the fetch unit: redirect target, pc+4 or hold.
// Ports: pc/advance/redirect/redirect_pc in, npc out. Purely combinational.
// A redirect always wins over the sequential advance.
module ysyx_ifu_npc (
   input  logic [31:0] pc,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] npc
);

   always_comb begin
      npc = pc;
      if (redirect) begin
         npc = redirect_pc;
      end else if (advance) begin
         npc = pc + 32'd4;   // wraps silently at 2^32
      end
   end

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding imem read, result handed to decode via valid/ready.
// Ports: imem_req_*/imem_rsp_* toward memory, out_* toward decode, redirect_* from execute.
// Latency: request N, response N+1, out_valid N+2; out_ready low holds the word in HOLD.
module ysyx_ifu
   import ysyx_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   ifu_state_t  state;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        drop;      // the outstanding response belongs to a superseded pc

   logic accept;
   logic redir_ok;
   logic redir_bad;
   logic advance;

   // imem_req_valid is registered, so it already encodes "in REQ and out of reset".
   assign accept    = (state == ST_REQ) && imem_req_valid && imem_req_ready;
   assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
   assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign advance   = (state == ST_WAIT) && imem_rsp_valid && !drop && !imem_rsp_err
                      && !redirect_valid;

   ysyx_ifu_npc u_npc (
      .pc          (pc),
      .advance     (advance),
      .redirect    (redir_ok),
      .redirect_pc (redirect_pc),
      .npc         (npc)
   );

   // The fetch address is the pc register itself, so it is stable in REQ by construction.
   assign imem_req_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_REQ;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         imem_req_valid <= 1'b0;
         out_valid      <= 1'b0;
         out_inst       <= NOP_INST;
         out_pc         <= RESET_PC;
         fetch_fault    <= 1'b0;
      end else begin
         pc <= npc;
         if (redir_bad) begin
            state          <= ST_FAULT;
            out_pc         <= redirect_pc;
            fetch_fault    <= 1'b1;
            imem_req_valid <= 1'b0;
            out_valid      <= 1'b0;
            // Remember a request still in flight so its response is swallowed later.
            if (accept || ((state == ST_WAIT) && !imem_rsp_valid)) begin
               drop <= 1'b1;
            end else if (state == ST_WAIT) begin
               drop <= 1'b0;
            end
         end else if (redir_ok) begin
            fetch_fault <= 1'b0;
            out_valid   <= 1'b0;
            case (state)
               ST_REQ: begin
                  if (accept) begin
                     state          <= ST_WAIT;
                     drop           <= 1'b1;
                     imem_req_valid <= 1'b0;
                  end else begin
                     imem_req_valid <= 1'b1;
                  end
               end
               ST_WAIT: begin
                  if (imem_rsp_valid) begin
                     state          <= ST_REQ;
                     drop           <= 1'b0;
                     imem_req_valid <= 1'b1;
                  end else begin
                     drop <= 1'b1;
                  end
               end
               default: begin   // HOLD (handshake counts if out_ready) and FAULT
                  state          <= ST_REQ;
                  imem_req_valid <= 1'b1;
               end
            endcase
         end else begin
            case (state)
               ST_REQ: begin
                  if (accept) begin
                     state          <= ST_WAIT;
                     imem_req_valid <= 1'b0;
                  end else begin
                     imem_req_valid <= 1'b1;
                  end
               end
               ST_WAIT: begin
                  if (imem_rsp_valid) begin
                     if (drop) begin
                        state          <= ST_REQ;
                        drop           <= 1'b0;
                        imem_req_valid <= 1'b1;
                     end else if (imem_rsp_err) begin
                        state       <= ST_FAULT;
                        out_pc      <= pc;
                        fetch_fault <= 1'b1;
                     end else begin
                        state     <= ST_HOLD;
                        out_inst  <= imem_rsp_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  if (out_ready) begin
                     state          <= ST_REQ;
                     out_valid      <= 1'b0;
                     imem_req_valid <= 1'b1;
                  end
               end
               default: begin   // FAULT: a stale response that lands here clears drop
                  if (imem_rsp_valid) begin
                     drop <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ysyx_ifu.md
# ysyx_ifu

Instruction fetch unit for the ysyx multi-cycle core. It owns the PC, issues one 32-bit instruction read at a time to instruction memory, and hands each returned word with its PC to the decode stage through a valid/ready handshake. It also accepts PC redirects from execute (jal/jalr/taken branch). It sits between the instruction-memory port and the decoder, on the producer side of the instruction stream.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_rsp_valid  in  1  response valid (exactly one per accepted request).
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid.
- out_valid  out  1  inst/pc valid toward decode.
- out_ready  in  1  decode consumes this cycle.
- out_inst  out  32  fetched instruction.
- out_pc  out  32  PC of out_inst, or faulting PC when fetch_fault=1.
- redirect_valid  in  1  single-cycle redirect pulse from execute.
- redirect_pc  in  32  redirect target.
- fetch_fault  out  1  sticky fetch fault (bus error or misaligned target).

## Operation
- States: REQ, WAIT, HOLD, FAULT. Leaving reset, the FSM is in REQ with pc = RESET_PC.
- REQ: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready=1, go to WAIT. Otherwise stay; addr stays stable unless a redirect occurs.
- WAIT: wait for imem_rsp_valid.
  - If drop=1: discard the response, clear drop, go to REQ. No out_valid.
  - Else if imem_rsp_err=1: go to FAULT, out_pc=pc.
  - Else: latch out_inst=imem_rsp_data and out_pc=pc, set pc=pc+4 (mod 2^32, wrap silent), go to HOLD.
- HOLD: out_valid=1, and out_inst/out_pc are held stable. When out_ready=1, go to REQ.
- FAULT: fetch_fault=1, no requests, out_valid=0. Only a redirect leaves this state.
- Redirect (any state):
  - If redirect_pc[1:0]≠0: go to FAULT, out_pc=redirect_pc.
  - Otherwise set pc=redirect_pc and clear fetch_fault.
  - REQ, not accepted this cycle: stay in REQ with the new addr.
  - REQ, accepted this cycle: go to WAIT with drop=1.
  - WAIT: stay in WAIT, set drop=1. If a response also arrives that cycle, discard it and go to REQ with drop=0.
  - HOLD: go to REQ. If out_ready is high in the same cycle, the handshake still counts as completed.
  - FAULT: go to REQ.
- Redirect wins over every other same-cycle event that updates pc.
- At most one request is outstanding; no speculative prefetch.

## Timing
- Reset values: state=REQ, pc=RESET_PC, drop=0, imem_req_valid=0 while rst=1 (1 from the first cycle after release), imem_req_addr=RESET_PC, out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=RESET_PC, fetch_fault=0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Zero-wait memory (ready=1, rsp one cycle after accept): request cycle N, response N+1, out_valid N+2. Throughput is one instruction per 3 cycles when out_ready=1.
- out_valid drops the cycle after a handshake or a redirect.
- rst asserted mid-WAIT: the FSM returns to its reset state immediately. A late response after release is ignored in REQ, because responses are only sampled in WAIT. Memory is reset together with the core.

## Structure
- The shared package ysyx_pkg holds: the ifu state enum (REQ/WAIT/HOLD/FAULT), the default RESET_PC, and the NOP constant 32'h0000_0013.
- The next-PC mux (pc+4 / redirect / hold) is a small local sub-module, ysyx_ifu_npc. Everything else is flat.

## Test plan
- Reset release, zero-wait memory, data 0x00100093 at 0x80000000: first request addr 0x80000000; out_valid on the 3rd cycle with out_inst=0x00100093, out_pc=0x80000000; next request addr 0x80000004.
- Backpressure: out_ready=0 for 5 cycles in HOLD: out_inst/out_pc stable, imem_req_valid=0. Then out_ready=1 for 1 cycle: REQ follows.
- Redirect to 0x80000100 during WAIT with a 3-cycle memory latency: the stale response is dropped, out_valid never asserts for it, and the next request addr is 0x80000100.
- Redirect in the same cycle as imem_req_ready: the old-addr response is discarded, then the fetch from the redirect target completes normally.
- imem_rsp_err=1 at pc 0x80000008: fetch_fault=1, out_pc=0x80000008, no further requests. Redirect to 0x80000000 clears the fault and resumes fetching.
- Redirect to 0x80000002: fetch_fault=1, out_pc=0x80000002, imem_req_valid stays 0.
